// File: rtl/dmem_master.sv
// Initiator-side controller for the 256x8 synchronous data memory: sequences single-byte
// loads/stores and forward block copies behind a valid/ready request handshake.
module dmem_master #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [AW-1:0] req_dst,
  input  logic [7:0]    req_len,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic          busy,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_write_data,
  output logic          mem_memread,
  output logic          mem_memwrite,
  input  logic [DW-1:0] mem_read_data
);

  typedef enum logic [2:0] {
    StIdle,
    StLdRd,
    StLdCap,
    StStWr,
    StCpRd,
    StCpWr
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_err_q, resp_err_d;
  logic          accept;

  assign req_ready  = (state_q == StIdle) & ~reset;
  assign accept     = req_valid & req_ready;
  assign busy       = (state_q != StIdle);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = rdata_q;

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          src_d   = req_addr;
          dst_d   = req_dst;
          len_d   = req_len;
          wdata_d = req_wdata;
          cnt_d   = 8'd0;
          unique case (req_op)
            2'b00: state_d = StLdRd;
            2'b01: state_d = StStWr;
            2'b10: begin
              if (req_len == 8'd0) resp_valid_d = 1'b1;
              else                 state_d      = StCpRd;
            end
            default: begin
              resp_valid_d = 1'b1;
              resp_err_d   = 1'b1;
            end
          endcase
        end
      end
      StLdRd:  state_d = StLdCap;
      StLdCap: begin
        rdata_d      = mem_read_data;
        resp_valid_d = 1'b1;
        state_d      = StIdle;
      end
      StStWr: begin
        resp_valid_d = 1'b1;
        state_d      = StIdle;
      end
      StCpRd:  state_d = StCpWr;
      StCpWr: begin
        if (cnt_q == len_q - 8'd1) begin
          rdata_d      = mem_read_data;
          resp_valid_d = 1'b1;
          state_d      = StIdle;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          state_d = StCpRd;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobes come from registered state only; copy write data is the memory's read
  // register, valid because the previous CP_RD edge loaded it.
  always_comb begin
    mem_memread    = 1'b0;
    mem_memwrite   = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    unique case (state_q)
      StLdRd: begin
        mem_memread = 1'b1;
        mem_address = src_q;
      end
      StStWr: begin
        mem_memwrite   = 1'b1;
        mem_address    = src_q;
        mem_write_data = wdata_q;
      end
      StCpRd: begin
        mem_memread = 1'b1;
        mem_address = src_q + AW'(cnt_q);
      end
      StCpWr: begin
        mem_memwrite   = 1'b1;
        mem_address    = dst_q + AW'(cnt_q);
        mem_write_data = mem_read_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_dmem_master.sv
// Randomized bench for dmem_master: a behavioural memory sits on the mem_* port and a
// byte-array reference model predicts responses, latencies, strobe counts and contents.
module tb_dmem_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_addr, req_dst, req_len, req_wdata;
  logic       resp_valid, resp_err, busy;
  logic [7:0] resp_rdata;
  logic [7:0] mem_address, mem_write_data, mem_read_data;
  logic       mem_memread, mem_memwrite;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  logic [7:0] model_rdata;
  int         n_vec  = 0;
  int         n_miss = 0;

  dmem_master #(.AW(8), .DW(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_addr       (req_addr),
    .req_dst        (req_dst),
    .req_len        (req_len),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .busy           (busy),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_memread    (mem_memread),
    .mem_memwrite   (mem_memwrite),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  // Synchronous memory: registered read, write has priority, read data holds otherwise.
  always @(posedge clk) begin
    if (mem_memwrite)     mem[mem_address] <= mem_write_data;
    else if (mem_memread) mem_read_data    <= mem[mem_address];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 256; i++) check_eq($sformatf("%s[%0d]", tag, i), mem[i], ref_mem[i]);
  endtask

  // Issue one request from an idle controller and check the full response.
  task automatic run_req(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] l, input logic [7:0] w);
    int         lat, exp_rd, exp_wr, k, rd_n, wr_n, busy_n, both_n;
    logic       exp_err;
    logic [7:0] si, di;
    exp_err = 1'b0;
    exp_rd  = 0;
    exp_wr  = 0;
    case (op)
      2'd0: begin lat = 3; exp_rd = 1; model_rdata = ref_mem[a]; end
      2'd1: begin lat = 2; exp_wr = 1; ref_mem[a] = w; end
      2'd2: begin
        lat    = 2 * int'(l) + 1;
        exp_rd = int'(l);
        exp_wr = int'(l);
        for (int i = 0; i < int'(l); i++) begin
          si = a + 8'(i);
          di = d + 8'(i);
          ref_mem[di] = ref_mem[si];
          model_rdata = ref_mem[si];
        end
      end
      default: begin lat = 1; exp_err = 1'b1; end
    endcase
    @(negedge clk);
    req_op = op; req_addr = a; req_dst = d; req_len = l; req_wdata = w;
    req_valid = 1'b1;
    check_eq("ready_before", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    k = 0; rd_n = 0; wr_n = 0; busy_n = 0; both_n = 0;
    while (!resp_valid && k < 600) begin
      rd_n   += int'(mem_memread);
      wr_n   += int'(mem_memwrite);
      busy_n += int'(busy);
      both_n += int'(mem_memread & mem_memwrite);
      @(negedge clk);
      k++;
    end
    check_eq($sformatf("latency op%0d", op), k + 1, lat);
    check_eq("resp_err", resp_err, exp_err);
    check_eq("resp_rdata", resp_rdata, model_rdata);
    check_eq("rd_strobes", rd_n, exp_rd);
    check_eq("wr_strobes", wr_n, exp_wr);
    check_eq("busy_cycles", busy_n, lat - 1);
    check_eq("strobe_excl", both_n, 0);
    @(negedge clk);
    check_eq("resp_pulse", resp_valid, 0);
  endtask

  initial begin
    int k;
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0;
    req_dst = '0; req_len = '0; req_wdata = '0;
    model_rdata = 8'h00;
    @(negedge clk);
    check_eq("rst_ready", req_ready, 0);
    repeat (2) @(negedge clk);
    check_eq("rst_outs", {resp_valid, resp_err, resp_rdata, busy, mem_memread, mem_memwrite,
                          mem_address, mem_write_data}, 0);
    reset = 1'b0;
    #1 check_eq("rst_release_ready", req_ready, 1);

    // Directed store then load.
    run_req(2'd1, 8'h10, 8'h00, 8'h00, 8'h5A);
    run_req(2'd0, 8'h10, 8'h00, 8'h00, 8'h00);
    check_eq("load_5a", resp_rdata, 8'h5A);

    // Back-to-back with req_valid held high.
    @(negedge clk);
    req_op = 2'd1; req_addr = 8'h00; req_wdata = 8'h01; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_op = 2'd0;
    @(negedge clk);
    check_eq("b2b_resp1", resp_valid, 1);
    check_eq("b2b_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("b2b_busy", busy, 1);
    k = 0;
    while (!resp_valid && k < 100) begin @(negedge clk); k++; end
    check_eq("b2b_latency", k + 1, 3);
    check_eq("b2b_rdata", resp_rdata, 8'h01);
    ref_mem[0] = 8'h01;
    model_rdata = 8'h01;
    @(negedge clk);

    // Fill memory with random bytes through the controller.
    for (int i = 0; i < 256; i++) run_req(2'd1, 8'(i), 8'h00, 8'h00, 8'($urandom));
    check_mem("fill");

    // Copy 4 bytes, wrap-around copy, overlapping copy.
    run_req(2'd1, 8'h20, 8'h00, 8'h00, 8'h11);
    run_req(2'd1, 8'h21, 8'h00, 8'h00, 8'h22);
    run_req(2'd1, 8'h22, 8'h00, 8'h00, 8'h33);
    run_req(2'd1, 8'h23, 8'h00, 8'h00, 8'h44);
    run_req(2'd2, 8'h20, 8'h40, 8'd4, 8'h00);
    check_eq("copy4_rdata", resp_rdata, 8'h44);
    check_eq("copy4_m43", mem[8'h43], 8'h44);
    run_req(2'd2, 8'hFE, 8'h02, 8'd3, 8'h00);
    run_req(2'd1, 8'h30, 8'h00, 8'h00, 8'hAA);
    run_req(2'd2, 8'h30, 8'h31, 8'd3, 8'h00);
    check_eq("overlap_m33", mem[8'h33], 8'hAA);
    check_mem("copies");

    // Zero-length copy and illegal op.
    run_req(2'd2, 8'h50, 8'h60, 8'd0, 8'h00);
    run_req(2'd3, 8'h50, 8'h60, 8'd5, 8'h00);

    // Random traffic.
    for (int i = 0; i < 40; i++)
      run_req(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
              8'($urandom_range(0, 24)), 8'($urandom));
    check_mem("random");

    // Reset during CP_WR of a len=8 copy.
    @(negedge clk);
    req_op = 2'd2; req_addr = 8'h80; req_dst = 8'hC0; req_len = 8'd8; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("abort_in_cpwr", mem_memwrite, 1);
    reset = 1'b1;
    #1 check_eq("abort_ready_rst", req_ready, 0);
    ref_mem[8'hC0] = ref_mem[8'h80];
    model_rdata = 8'h00;
    @(negedge clk);
    check_eq("abort_outs", {resp_valid, resp_err, resp_rdata, busy, mem_memread, mem_memwrite,
                            mem_address, mem_write_data}, 0);
    check_eq("abort_ready_rst2", req_ready, 0);
    reset = 1'b0;
    #1 check_eq("abort_ready_after", req_ready, 1);
    k = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); k += int'(resp_valid); end
    check_eq("abort_no_resp", k, 0);
    run_req(2'd0, 8'hC0, 8'h00, 8'h00, 8'h00);
    check_mem("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dmem_master.md
Name: dmem_master

Overview:
- Initiator-side controller for the 8-bit synchronous data memory (256 x 8; registered read; write has priority over read; read_data holds its value when not reading).
- Accepts single-byte load, single-byte store and block-copy requests from the CPU datapath over a valid/ready handshake.
- Sequences the memread/memwrite/address/write_data strobes and returns one completion pulse per request, with load data where applicable.

Parameters:
- AW, 8, address width; memory depth is 2^AW.
- DW, 8, data width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_op  in  2  00 load, 01 store, 10 copy, 11 illegal.
- req_addr  in  AW  load/store address, or copy source base.
- req_dst  in  AW  copy destination base.
- req_len  in  8  copy byte count (0..255).
- req_wdata  in  DW  store data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DW  load data, or the last byte copied.
- resp_err  out  1  qualifies resp_valid; high for an illegal op.
- busy  out  1  high while a request is in progress (state != IDLE).
- mem_address  out  AW  to memory address.
- mem_write_data  out  DW  to memory write_data.
- mem_memread  out  1  to memory memread.
- mem_memwrite  out  1  to memory memwrite.
- mem_read_data  in  DW  from memory read_data.

Behaviour:
- Reset: state=IDLE.
  - resp_valid, resp_err, resp_rdata, busy, mem_memread, mem_memwrite, mem_address and mem_write_data all 0.
  - req_ready is 0 in any cycle where reset=1.
  - Reset mid-operation aborts immediately; no resp_valid is issued for the aborted request.
- Handshake:
  - req_ready = (state==IDLE) & !reset.
  - A request is accepted on the edge where req_valid & req_ready; all request fields are latched at that edge.
  - Inputs are ignored in all other cycles.
- Strobes:
  - mem_* outputs are decoded from registered state only; they never depend combinationally on req_*.
  - mem_memread and mem_memwrite are never both high.
  - Both strobes are 0 in IDLE.
- States: IDLE, LD_RD, LD_CAP, ST_WR, CP_RD, CP_WR.
- Load (accept edge E0):
  - Cycle after E0: LD_RD, memread=1, address=addr.
  - E1: memory samples. Next cycle: LD_CAP, strobes 0.
  - E2: resp_rdata <= mem_read_data; state -> IDLE.
  - resp_valid=1 in the cycle after E2; req_ready is also 1 in that cycle.
  - Accept-to-response latency: 3 edges.
- Store:
  - Cycle after E0: ST_WR, memwrite=1, address=addr, write_data=wdata.
  - E1: write occurs; state -> IDLE; resp_valid=1 in the next cycle.
  - resp_rdata unchanged.
- Copy, len=0: no memory access; state stays IDLE; resp_valid=1 in the cycle after E0; resp_rdata unchanged.
- Copy, len>0: internal counter i=0..len-1 (8 bits). Two cycles per byte:
  - CP_RD: memread=1, address=src+i.
  - CP_WR: memwrite=1, address=dst+i, write_data=mem_read_data (a direct path; the data is valid because of the preceding read edge).
  - On the CP_WR edge: if i==len-1, resp_rdata <= mem_read_data and state -> IDLE; otherwise i <= i+1 and state -> CP_RD.
  - resp_valid occurs 2*len+1 edges after E0.
- Address arithmetic: src+i and dst+i are modulo 2^AW (wrap 0xFF -> 0x00).
- Overlap: the copy is strictly forward, byte by byte. When dst lies in (src, src+len), already-written bytes are re-read; the resulting pattern replication is the defined behaviour.
- Illegal op (11): no memory access; resp_valid=1 and resp_err=1 in the cycle after E0. resp_err=0 on every other response.
- resp_valid and resp_err are high for exactly one cycle per accepted request. resp_rdata holds its value between responses.
- busy=1 from the cycle after E0 through the last non-IDLE cycle.

Test Plan:
- Reset, then store 0x5A to 0x10, then load 0x10:
  - store resp_valid 2 edges after accept, with memwrite high exactly 1 cycle;
  - load resp_valid 3 edges after accept, resp_rdata=0x5A, memread high exactly 1 cycle.
- Back-to-back: req_valid held high with store 0x01@0x00 then load 0x00 → the second request is accepted in the same cycle as the first resp_valid; load returns 0x01.
- Copy src=0x20, dst=0x40, len=4 over preloaded 11,22,33,44:
  - memory at 0x40..0x43 = 11,22,33,44;
  - resp_valid 9 edges after accept; resp_rdata=0x44; strobes alternate read/write, never both high.
- Wrap and overlap:
  - copy src=0xFE, dst=0x02, len=3 → bytes from 0xFE, 0xFF, 0x00 land at 0x02..0x04;
  - copy src=0x30, dst=0x31, len=3 with 0x30=0xAA → 0x31..0x33 all 0xAA.
- len=0 copy and op=11:
  - no strobes asserted for either;
  - resp_valid 1 edge after accept for both;
  - resp_err=0 for the copy and 1 for op=11.
- Reset asserted during CP_WR of a len=8 copy:
  - next cycle all outputs are 0 and there is no resp_valid;
  - req_ready is 0 during the reset cycle and 1 in the first cycle after reset deasserts.
